uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised successor to the one-bit-per-clock UART receiver. Adds:
- configurable data width, oversampling (clocks per bit), parity mode (none/odd/even) and 1 or 2 stop bits;
- separate parity and framing error pulses.

It sits behind the serial input pin and delivers one received word per frame to downstream logic as a single-cycle pulse. Defaults reproduce the previous receiver's protocol exactly: 8 bits, 1 clock/bit, odd parity, 1 stop bit.

Parameters:
- DATA_WIDTH, 8, data bits per frame, LSB first; legal 5..16.
- CLKS_PER_BIT, 1, clock cycles per serial bit; legal 1..65535.
- PARITY_MODE, 1, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data  in  1  serial line; idle high.
- out_byte  out  DATA_WIDTH  last correctly received word.
- done  out  1  one-cycle pulse; out_byte is valid.
- parity_err  out  1  one-cycle pulse on parity mismatch.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled 0.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
  - During reset: state = IDLE; out_byte, done, parity_err, frame_err and all counters = 0.
  - Reset mid-frame aborts the frame. No done or error pulse is produced, and out_byte keeps 0.
- States: IDLE, START, DATA, PARITY, STOP, ERROR.
- Sample points:
  - Bit time N = CLKS_PER_BIT.
  - Start is detected at the edge where IDLE samples data = 0 (edge k).
  - The start bit is re-checked at edge k + N/2 (integer division).
  - Every later bit is sampled exactly N clocks after the previous sample.
- IDLE: data = 0 -> START with the cycle counter cleared. If N = 1, edge k is itself the start sample and the FSM goes directly to DATA.
- START: at the mid-bit sample:
  - data = 1 -> glitch; return to IDLE with no pulse.
  - data = 0 -> DATA.
- DATA: shift in DATA_WIDTH samples LSB first into an internal shift register.
  - After the last sample -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY: expected bit = XOR of the data bits, inverted for odd mode (data + parity has an odd number of 1s).
  - Mismatch -> parity_err = 1 for one cycle, then ERROR.
  - Match -> STOP.
- STOP: sample STOP_BITS bits.
  - Any sample 0 -> frame_err = 1 for one cycle, then ERROR.
  - After the final stop sample is 1: out_byte <= shift register and done = 1 for exactly one cycle (registered; visible the cycle after the final stop-sample edge), then IDLE.
  - Back-to-back frames: with N = 1 a start bit on the very next cycle is accepted. In general, IDLE is re-entered one cycle after the final stop sample.
- ERROR: wait until data is 1 for N consecutive clocks (one clock when N = 1), then IDLE.
  - out_byte is never updated on an errored frame.
  - A 0 while waiting restarts the count.
- done, parity_err and frame_err are mutually exclusive in any cycle.
- Counters:
  - cycle counter is clog2(CLKS_PER_BIT + 1) bits, saturating is not needed: it is cleared at each sample.
  - bit counter is clog2(DATA_WIDTH + 1) bits.
  - No wrap-around is permitted mid-frame.
- out_byte holds its value between done pulses.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: data passes through a two-flop synchroniser (both flops reset to 1) before the FSM. All sample points, and therefore done and the error pulses, are delayed by exactly 2 clocks.
- Undefined: data is used directly, for boards or benches with synchronous stimulus. Latency is as above.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, ERROR);
  - parity mode constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2;
  - a parity function taking word and mode.
- One sub-module, uart_bit_timer: counts CLKS_PER_BIT and issues sample_tick.
  - Restarts on a start-detect strobe.
  - First tick at N/2, then every N clocks.
  - Tick is held low in IDLE.

Test Plan:
- Defaults. Send 0xA9 (start 0, bits 1,0,0,1,0,1,0,1, parity 1, stop 1) -> done pulse one cycle, out_byte = 0xA9, no error pulses.
- Defaults, wrong parity. Data 0xAC with parity 0 -> parity_err pulse; line held 0 for 4 clocks keeps ERROR; line 1 -> IDLE. A following 0xA9 frame -> out_byte = 0xA9, done.
- Defaults, bad stop. Data 0x65, parity 1, stop 0 -> frame_err pulse, no done, out_byte unchanged (0xA9). Recovery after line high.
- CLKS_PER_BIT = 16, PARITY_MODE = 2, STOP_BITS = 2, DATA_WIDTH = 7.
  - Send 0x5A with even parity 0 -> done 1 clock after the second stop sample, out_byte = 0x5A.
  - A 5-clock low glitch on the idle line -> no pulses, state IDLE.
- Reset asserted after bit4 of a 0xA9 frame and held 3 clocks -> all outputs 0, no pulses. A next full 0xA9 frame -> done, out_byte = 0xA9.
- UART_RX_SYNC_EN defined, defaults, 0xA9 -> done exactly 2 clocks later than the unsynchronised run.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // Parity mode encodings
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Widest data word the receiver supports
  localparam int MAX_WIDTH = 16;

  // Expected parity bit for a zero-extended word; odd mode makes data+parity hold an odd count of ones
  function automatic logic parity_bit(input logic [MAX_WIDTH-1:0] word, input int mode);
    parity_bit = (^word) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: first tick half a bit after restart, then one tick per bit period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic half,
  output logic sample_tick
);

  localparam int CW      = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF_M1 = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] target;

  // Terminal count: half a bit for the start re-check, a full bit otherwise
  always_comb begin
    target      = half ? CW'(HALF_M1) : CW'(CLKS_PER_BIT - 1);
    sample_tick = active && !start && (cnt_reg == target);
  end

  // Cycle counter, cleared at every sample, on restart and while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (start || !active || sample_tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width, oversampling, parity and stop bits.
// Optional macro UART_RX_SYNC_EN inserts a two-flop input synchroniser (adds 2 clocks of latency).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data,
  output logic [DATA_WIDTH-1:0] out_byte,
  output logic                  done,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  logic line_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_reg;

  // Two-flop synchroniser, idle-high out of reset so no false start is seen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], data};
    end
  end

  assign line_s = sync_reg[1];
`else
  assign line_s = data;
`endif

  state_t                state_reg;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BW-1:0]         bit_cnt_reg;
  logic                  stop_cnt_reg;
  logic                  done_reg;
  logic                  parity_err_reg;
  logic                  frame_err_reg;
  logic [DATA_WIDTH-1:0] out_byte_reg;

  logic                  tick;
  logic                  start_det;
  logic                  timer_restart;
  logic                  last_data;
  logic                  last_stop;
  logic                  par_exp;
  logic [MAX_WIDTH-1:0]  word_ext;
  logic                  done_next;
  logic                  parity_err_next;
  logic                  frame_err_next;

  // Start detection and timer control; an ERROR-state low restarts the idle-line count
  always_comb begin
    start_det     = (state_reg == IDLE) && !line_s;
    timer_restart = start_det || ((state_reg == ERROR) && !line_s);
    last_data     = (bit_cnt_reg == BW'(DATA_WIDTH - 1));
    last_stop     = (stop_cnt_reg == 1'(STOP_BITS - 1));
    word_ext      = '0;
    word_ext[DATA_WIDTH-1:0] = shift_reg;
    par_exp       = parity_bit(word_ext, PARITY_MODE);
  end

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .start       (timer_restart),
    .active      (state_reg != IDLE),
    .half        (state_reg == START),
    .sample_tick (tick)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; with one clock per bit the start-detect edge is also the start sample
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!line_s) state_next = (CLKS_PER_BIT == 1) ? DATA : START;
      end
      START: begin
        if (tick) state_next = line_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick && last_data) state_next = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
      end
      PARITY: begin
        if (tick) state_next = (line_s != par_exp) ? ERROR : STOP;
      end
      STOP: begin
        if (tick) begin
          if (!line_s)        state_next = ERROR;
          else if (last_stop) state_next = IDLE;
        end
      end
      ERROR: begin
        if (tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pulse decode; at most one of these can be true for a given sample
  always_comb begin
    done_next       = (state_reg == STOP) && tick && line_s && last_stop;
    parity_err_next = (state_reg == PARITY) && tick && (line_s != par_exp);
    frame_err_next  = (state_reg == STOP) && tick && !line_s;
  end

  // Data path: LSB-first shift register, data-bit and stop-bit counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE) begin
        bit_cnt_reg  <= '0;
        stop_cnt_reg <= 1'b0;
      end
      if ((state_reg == DATA) && tick) begin
        shift_reg   <= {line_s, shift_reg[DATA_WIDTH-1:1]};
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
      if ((state_reg == STOP) && tick) begin
        stop_cnt_reg <= stop_cnt_reg + 1'b1;
      end
    end
  end

  // Registered outputs; the word is only captured on a clean frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_reg       <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      out_byte_reg   <= '0;
    end else begin
      done_reg       <= done_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
      if (done_next) out_byte_reg <= shift_reg;
    end
  end

  assign out_byte   = out_byte_reg;
  assign done       = done_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;

endmodule
